// File: rtl/snake_pkg.sv
// Shared types and playfield limits for the snake game sequencer.
package snake_pkg;

  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    RIGHT = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    CHECK,
    EAT,
    DEAD
  } state_t;

  localparam int GRID  = 20;
  localparam int X_MIN = 20;
  localparam int X_MAX = 600;
  localparam int Y_MIN = 20;
  localparam int Y_MAX = 440;

  function automatic logic wall_hit(input logic [9:0] x, input logic [8:0] y);
    return (x < 10'(X_MIN)) || (x > 10'(X_MAX)) ||
           (y < 9'(Y_MIN))  || (y > 9'(Y_MAX));
  endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Frame counter that fires once per move interval; the interval shrinks
// by one frame every SPEEDUP_EVERY eats, down to MIN_FRAMES.
module snake_step_timer #(
  parameter int FRAMES_PER_STEP = 8,
  parameter int MIN_FRAMES      = 3,
  parameter int SPEEDUP_EVERY   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic eat,
  input  logic frame_stb,
  output logic expire
);

  localparam int CW = $clog2(FRAMES_PER_STEP + 1);
  localparam int EW = $clog2(SPEEDUP_EVERY + 1);

  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] interval;
  logic [EW-1:0] eat_cnt;

  assign expire = frame_stb && (frame_cnt == interval - CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      interval  <= CW'(FRAMES_PER_STEP);
      eat_cnt   <= '0;
    end else if (clear) begin
      frame_cnt <= '0;
      interval  <= CW'(FRAMES_PER_STEP);
      eat_cnt   <= '0;
    end else begin
      if (frame_stb) begin
        frame_cnt <= expire ? '0 : frame_cnt + CW'(1);
      end
      if (eat) begin
        if (eat_cnt == EW'(SPEEDUP_EVERY - 1)) begin
          eat_cnt <= '0;
          if (interval > CW'(MIN_FRAMES)) begin
            interval <= interval - CW'(1);
          end
        end else begin
          eat_cnt <= eat_cnt + EW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/snake_ctrl.sv
// Snake game sequencer: paces move steps from the frame strobe, arbitrates
// buttons into a legal direction and resolves wall/body/food after each step.
module snake_ctrl
  import snake_pkg::*;
#(
  parameter int INIT_LEN        = 4,
  parameter int MAX_LEN         = 14,
  parameter int FRAMES_PER_STEP = 8,
  parameter int MIN_FRAMES      = 3,
  parameter int SPEEDUP_EVERY   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_stb,
  input  logic       btn_u,
  input  logic       btn_l,
  input  logic       btn_d,
  input  logic       btn_r,
  input  logic [9:0] head_x,
  input  logic [8:0] head_y,
  input  logic [9:0] food_x,
  input  logic [8:0] food_y,
  input  logic       body_hit,
  output logic [1:0] dir,
  output logic       step,
  output logic       grow,
  output logic       food_req,
  output logic       restart,
  output logic [3:0] len,
  output logic       game_over
);

  state_t state, state_n;
  dir_t   dir_q, pending, win;
  logic   any_btn, expire, released, restart_n;

  assign any_btn = btn_u | btn_l | btn_d | btn_r;
  assign dir     = dir_q;

  always_comb begin
    win = RIGHT;
    if (btn_u)      win = UP;
    else if (btn_l) win = LEFT;
    else if (btn_d) win = DOWN;
  end

  snake_step_timer #(
    .FRAMES_PER_STEP (FRAMES_PER_STEP),
    .MIN_FRAMES      (MIN_FRAMES),
    .SPEEDUP_EVERY   (SPEEDUP_EVERY)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state == IDLE),
    .eat       (state == EAT),
    .frame_stb (frame_stb && (state == RUN)),
    .expire    (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    restart_n = 1'b0;
    case (state)
      IDLE:  if (any_btn) state_n = RUN;
      RUN:   if (expire) state_n = STEP;
      STEP:  state_n = CHECK;
      // Death is tested first so a fatal move onto food never counts as an eat.
      CHECK: begin
        if (wall_hit(head_x, head_y) || body_hit)           state_n = DEAD;
        else if ((head_x == food_x) && (head_y == food_y))  state_n = EAT;
        else                                                state_n = RUN;
      end
      EAT:   state_n = RUN;
      DEAD: begin
        if (released && any_btn) begin
          state_n   = IDLE;
          restart_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Pulses are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step      <= 1'b0;
      grow      <= 1'b0;
      food_req  <= 1'b0;
      restart   <= 1'b0;
      game_over <= 1'b0;
      len       <= 4'(INIT_LEN);
      released  <= 1'b0;
    end else begin
      step      <= (state_n == STEP);
      grow      <= (state_n == EAT) && (len < 4'(MAX_LEN));
      food_req  <= (state_n == EAT);
      restart   <= restart_n;
      game_over <= (state_n == DEAD);
      if (restart_n)                                  len <= 4'(INIT_LEN);
      else if ((state_n == EAT) && (len < 4'(MAX_LEN))) len <= len + 4'd1;
      if (state != DEAD)   released <= 1'b0;
      else if (!any_btn)   released <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q   <= RIGHT;
      pending <= RIGHT;
    end else if (restart_n) begin
      dir_q   <= RIGHT;
      pending <= RIGHT;
    end else begin
      if (((state == IDLE) || (state == RUN)) && any_btn &&
          (win != dir_t'(dir_q ^ 2'b01))) begin
        pending <= win;
      end
      if ((state == RUN) && expire && (pending != dir_t'(dir_q ^ 2'b01))) begin
        dir_q <= pending;
      end
    end
  end

endmodule

// File: tb/tb_snake_ctrl.sv
// Scoreboard bench for snake_ctrl: stimulus queues expected events, a
// negedge monitor pops and compares whenever the DUT emits one.
module tb_snake_ctrl;

  localparam int K_STEP  = 0;
  localparam int K_EAT   = 1;
  localparam int K_DEAD  = 2;
  localparam int K_RST   = 3;
  localparam int K_PROBE = 4;
  localparam int K_END   = 5;

  typedef struct {
    int kind;
    int dir;
    int len;
    int grow;
    int frm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_stb = 1'b0;
  logic       btn_u = 1'b0, btn_l = 1'b0, btn_d = 1'b0, btn_r = 1'b0;
  logic [9:0] head_x = 10'd100;
  logic [8:0] head_y = 9'd100;
  logic [9:0] food_x = 10'd300;
  logic [8:0] food_y = 9'd200;
  logic       body_hit = 1'b0;
  logic [1:0] dir;
  logic       step, grow, food_req, restart, game_over;
  logic [3:0] len;

  logic probe = 1'b0;
  logic done = 1'b0;
  exp_t q[$];
  exp_t e;
  int total = 0, bad = 0;
  int cyc = 0, frm_seen = 0, step_cyc = 0;
  int nfr = 0;
  logic go_prev = 1'b0;

  // eat table: frames before step, len at step, len after eat, grow
  int eat_frm  [11] = '{8, 8, 8, 8, 7, 7, 7, 7, 6, 6, 6};
  int eat_lenb [11] = '{4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
  int eat_lena [11] = '{5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 14};
  int eat_grow [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

  snake_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_stb (frame_stb),
    .btn_u     (btn_u),
    .btn_l     (btn_l),
    .btn_d     (btn_d),
    .btn_r     (btn_r),
    .head_x    (head_x),
    .head_y    (head_y),
    .food_x    (food_x),
    .food_y    (food_y),
    .body_hit  (body_hit),
    .dir       (dir),
    .step      (step),
    .grow      (grow),
    .food_req  (food_req),
    .restart   (restart),
    .len       (len),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic pop(output exp_t r);
    if (q.size() == 0) begin
      r = '{kind: -1, dir: 0, len: 0, grow: 0, frm: 0};
    end else begin
      r = q.pop_front();
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (frame_stb) frm_seen++;
    if (probe) begin
      pop(e);
      if (e.kind == K_END) begin
        chk("leftover_events", q.size(), 0);
        done = 1'b1;
      end else begin
        chk("probe_kind", e.kind, K_PROBE);
        chk("probe_step", int'(step), 0);
        chk("probe_grow", int'(grow), 0);
        chk("probe_food_req", int'(food_req), 0);
        chk("probe_restart", int'(restart), 0);
        chk("probe_game_over", int'(game_over), e.grow);
        chk("probe_dir", int'(dir), e.dir);
        chk("probe_len", int'(len), e.len);
      end
    end
    if (step) begin
      pop(e);
      chk("step_kind", e.kind, K_STEP);
      chk("step_dir", int'(dir), e.dir);
      chk("step_len", int'(len), e.len);
      chk("step_frame", frm_seen, e.frm);
      step_cyc = cyc;
    end
    if (food_req) begin
      pop(e);
      chk("eat_kind", e.kind, K_EAT);
      chk("eat_grow", int'(grow), e.grow);
      chk("eat_len", int'(len), e.len);
      chk("eat_latency", cyc - step_cyc, 2);
    end
    if (game_over && !go_prev) begin
      pop(e);
      chk("dead_kind", e.kind, K_DEAD);
      chk("dead_len", int'(len), e.len);
    end
    if (restart) begin
      pop(e);
      chk("restart_kind", e.kind, K_RST);
      chk("restart_len", int'(len), e.len);
      chk("restart_dir", int'(dir), e.dir);
      chk("restart_game_over", int'(game_over), 0);
    end
    go_prev = game_over;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int d, input int l, input int g, input int f);
    q.push_back('{kind: kind, dir: d, len: l, grow: g, frm: f});
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_stb = 1'b1;
      tick();
      frame_stb = 1'b0;
      nfr++;
      repeat (5) tick();
    end
  endtask

  task automatic do_probe(input int d, input int l, input int go);
    push(K_PROBE, d, l, go, 0);
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    do_probe(1, 4, 0);

    // idle frames are ignored
    frames(50);
    do_probe(1, 4, 0);
    btn_r = 1'b1; tick(); btn_r = 1'b0;
    push(K_STEP, 1, 4, 0, nfr + 8);
    frames(8);

    // reverse request ignored, U beats L
    btn_l = 1'b1; tick(); btn_l = 1'b0;
    push(K_STEP, 1, 4, 0, nfr + 8);
    frames(8);
    btn_u = 1'b1; btn_l = 1'b1; tick(); btn_u = 1'b0; btn_l = 1'b0;
    push(K_STEP, 2, 4, 0, nfr + 8);
    frames(8);

    // every step eats; interval shrinks after each fourth eat, length saturates
    head_x = 10'd300; head_y = 9'd200;
    for (int i = 0; i < 11; i++) begin
      push(K_STEP, 2, eat_lenb[i], 0, nfr + eat_frm[i]);
      push(K_EAT, 0, eat_lena[i], eat_grow[i], 0);
      frames(eat_frm[i]);
    end

    // wall hit on the food square: death wins
    head_x = 10'd620; food_x = 10'd620;
    push(K_STEP, 2, 14, 0, nfr + 6);
    push(K_DEAD, 0, 14, 0, 0);
    frames(6);
    frames(4);
    push(K_RST, 1, 4, 0, 0);
    btn_d = 1'b1; tick(); btn_d = 1'b0;
    repeat (3) tick();
    do_probe(1, 4, 0);

    head_x = 10'd100; head_y = 9'd100; food_x = 10'd300; food_y = 9'd200;
    btn_r = 1'b1; tick(); btn_r = 1'b0;
    push(K_STEP, 1, 4, 0, nfr + 8);
    frames(8);

    head_x = 10'd300; head_y = 9'd200;
    push(K_STEP, 1, 4, 0, nfr + 8);
    push(K_EAT, 0, 5, 1, 0);
    frames(8);

    // async reset asserted while step is high
    frames(7);
    frame_stb = 1'b1;
    tick();
    frame_stb = 1'b0;
    nfr++;
    rst_n = 1'b0;
    do_probe(1, 4, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    push(K_END, 0, 0, 0, 0);
    probe = 1'b1;
    tick();
    probe = 1'b0;
    for (int i = 0; i < 20 && !done; i++) tick();
    if (!done) begin
      $display("FAIL monitor_done: got 0 want 1");
      $fatal(1, "monitor did not finish");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snake_ctrl.md
# snake_ctrl

Game sequencer for the VGA snake datapath. It turns the per-frame strobe into move steps at a speed that rises as food is eaten. It arbitrates the four pushbuttons into a legal direction and checks wall, body and food events after every step. It emits the single-cycle `step`, `grow`, `food_req` and `restart` pulses that drive the body shift register and the food generator.

## Interface
- `INIT_LEN`, 4: snake length after reset/restart.
- `MAX_LEN`, 14: length saturation (head + 13 body blocks).
- `FRAMES_PER_STEP`, 8: initial frames per move step.
- `MIN_FRAMES`, 3: fastest step interval.
- `SPEEDUP_EVERY`, 4: eats per interval decrement.
- `clk`  in  1  system clock (100 MHz).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `frame_stb`  in  1  one-cycle pulse per video frame.
- `btn_u`, `btn_l`, `btn_d`, `btn_r`  in  1 each  pushbuttons, level, already synchronised.
- `head_x`  in  10  head top-left x, from datapath.
- `head_y`  in  9  head top-left y.
- `food_x`  in  10  food top-left x, grid-aligned.
- `food_y`  in  9  food top-left y, grid-aligned.
- `body_hit`  in  1  head overlaps any live body block, valid in CHECK.
- `dir`  out  2  committed direction: 0 left, 1 right, 2 up, 3 down.
- `step`  out  1  advance head/body one block.
- `grow`  out  1  extend body by one.
- `food_req`  out  1  request new food position.
- `restart`  out  1  datapath returns to initial positions.
- `len`  out  4  current length.
- `game_over`  out  1  high in DEAD.

## Operation
- Reset values: state IDLE, `dir`=1, pending dir=1, `len`=INIT_LEN, interval=FRAMES_PER_STEP, frame count 0, eat count 0, all pulses 0, `game_over`=0.
- Button arbitration in IDLE and RUN only. Priority U > L > D > R. The winning code is written to the pending register unless it equals `dir`^1 (reverse of committed direction).
- States and transitions:
  - IDLE: any button → RUN.
  - RUN: count `frame_stb`. When count==interval-1 and `frame_stb` is high → STEP, count cleared. On that edge `dir` ← pending, unless pending==`dir`^1, in which case `dir` is held.
  - STEP (1 cycle): `step`=1 → CHECK.
  - CHECK (1 cycle): a wall hit exists when `head_x`<20, `head_x`>600, `head_y`<20 or `head_y`>440.
    - Wall hit or `body_hit` → DEAD.
    - Else `head_x`==`food_x` and `head_y`==`food_y` → EAT.
    - Else → RUN.
  - EAT (1 cycle): `food_req`=1. `grow`=1 and `len`+1 only if `len`<MAX_LEN. Eat count +1; on reaching SPEEDUP_EVERY it clears, and interval decrements if > MIN_FRAMES → RUN.
  - DEAD: `game_over`=1. Wait for all buttons released ≥1 cycle, then any button → IDLE with `restart`=1 for that cycle.
- Entering IDLE restores `len`, interval, counters and `dir`/pending=1.
- `frame_stb` outside RUN is ignored.
- Death beats eat when both happen in the same CHECK.

## Timing
- All outputs are registered.
- `step` is high exactly one cycle, with `dir` already stable in that cycle.
- The datapath updates the head on the edge ending STEP, and CHECK samples the new head.
- `grow`/`food_req` go high 2 cycles after `step`.
- Step period = interval frames + 2–3 clocks.
- `rst_n` low mid-operation drives all outputs to reset values immediately, without waiting for `clk`.

## Structure
- `snake_pkg`: `dir_t` enum (LEFT=0, RIGHT=1, UP=2, DOWN=3), `state_t` enum (IDLE, RUN, STEP, CHECK, EAT, DEAD), GRID=20, X_MIN=20, X_MAX=600, Y_MIN=20, Y_MAX=440.
- Sub-module `snake_step_timer`: frame counter, interval register and eat counter. Inputs `clear`, `eat`, `frame_stb`; output `expire`.

## Test plan
- Reset, 50 frames with no button → IDLE, no `step`, `dir`=1, `len`=4. Press `btn_r` → first `step` after 8 `frame_stb`, `dir`=1.
- With `dir`=1, press `btn_l` → next step `dir`=1. Press `btn_u` and `btn_l` in the same cycle → next step `dir`=2.
- Head=(300,200)=food after a step → `food_req`/`grow` 2 cycles after `step`, `len` 4→5. After 4 eats the interval drops to 7 frames.
- `len`=14 with eat → `food_req`=1, `grow`=0, `len` stays 14.
- `head_x`=620 at CHECK while also equal to food → DEAD, `game_over`=1, no `food_req`, no further `step`. Release buttons, press `btn_d` → `restart` pulse, IDLE, `len`=4, interval 8.
- Assert `rst_n` low during STEP → `step`, `game_over` go 0 and `len`=4 with no clock edge.
